// File: rtl/tx_bit_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | tx_seq_pkg : shared types and constants for tx_bit_sequencer         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package tx_seq_pkg;

  localparam int NUM_DATA_BITS = 16;
  localparam int SEL_W         = $clog2(NUM_DATA_BITS);
  localparam logic TX_IDLE_LVL = 1'b1;

  // ST_PARITY is only reachable when TX_PARITY_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/tx_bit_sequencer_baud.sv
// +----------------------------------------------------------------------+
// | baud_tick_counter : per-bit clock counter, flags the last clock      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module baud_tick_counter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  logic [CNT_W-1:0] r_cnt;

  assign bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Wrapping on bit_end doubles as the clear at every bit boundary
  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_bit_sequencer.sv
// +----------------------------------------------------------------------+
// | tx_bit_sequencer : frames 16 mux-selected bits onto a serial line    |
// | Optional parity bit: define TX_PARITY_EN.            Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module tx_bit_sequencer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  output logic [3:0] mux_sel,
  input  logic       mux_bit,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  import tx_seq_pkg::*;

  tx_state_t        r_state, w_state_nxt;
  logic             r_tx, w_tx_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_bit_end;
`ifdef TX_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign start_ready = (r_state == ST_IDLE);
  assign mux_sel     = r_sel;
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign done        = r_done;

  // Held clear through IDLE so the START period begins at count 0
  baud_tick_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ready),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tx    <= TX_IDLE_LVL;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start_valid) begin
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_sel_nxt   = '0;
`ifdef TX_PARITY_EN
          w_par_nxt   = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = mux_bit;
          w_sel_nxt   = SEL_W'(1);
`ifdef TX_PARITY_EN
          w_par_nxt   = r_par ^ mux_bit;
`endif
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          // A select of zero here means it wrapped past 15: data is done
          if (r_sel != '0) begin
            w_tx_nxt  = mux_bit;
            w_sel_nxt = r_sel + SEL_W'(1);
`ifdef TX_PARITY_EN
            w_par_nxt = r_par ^ mux_bit;
`endif
          end else begin
`ifdef TX_PARITY_EN
            w_tx_nxt    = r_par;
            w_state_nxt = ST_PARITY;
`else
            w_tx_nxt    = TX_IDLE_LVL;
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_tx_nxt    = TX_IDLE_LVL;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = TX_IDLE_LVL;
        w_busy_nxt  = 1'b0;
        w_sel_nxt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_bit_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_tx_bit_sequencer : bench for tx_bit_sequencer (4 and 2 clk/bit)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tx_bit_sequencer;

  localparam int C0 = 4;
  localparam int C1 = 2;
`ifdef TX_PARITY_EN
  localparam int NBITS = 19;
`else
  localparam int NBITS = 18;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, sv0 = 1'b0, rst1 = 1'b1, sv1 = 1'b0;
  logic [15:0] word0 = 16'h0000, word1 = 16'h0000;
  logic [3:0]  sel0, sel1;
  logic        mb0, mb1;
  logic        tx0, busy0, done0, rdy0;
  logic        tx1, busy1, done1, rdy1;

  assign mb0 = word0[sel0];
  assign mb1 = word1[sel1];

  tx_bit_sequencer #(.CLKS_PER_BIT(C0)) dut0 (
    .clk(clk), .rst(rst0), .start_valid(sv0), .start_ready(rdy0),
    .mux_sel(sel0), .mux_bit(mb0), .tx(tx0), .busy(busy0), .done(done0)
  );

  tx_bit_sequencer #(.CLKS_PER_BIT(C1)) dut1 (
    .clk(clk), .rst(rst1), .start_valid(sv1), .start_ready(rdy1),
    .mux_sel(sel1), .mux_bit(mb1), .tx(tx1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: position p of the frame is start, data LSB-first, [parity], stop
  function automatic logic frame_bit(input logic [15:0] w, input int p);
    if (p == 0) return 1'b0;
    if (p <= 16) return w[p-1];
`ifdef TX_PARITY_EN
    if (p == 17) return ^w;
`endif
    return 1'b1;
  endfunction

  int  cpb [2] = '{C0, C1};
  bit  m_act [2];
  bit  m_done [2];
  int  m_k [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic r, v;
      r = (i == 0) ? rst0 : rst1;
      v = (i == 0) ? sv0 : sv1;
      m_done[i] = 1'b0;
      if (r) begin
        m_act[i] = 1'b0;
        m_k[i]   = 0;
      end else if (m_act[i]) begin
        m_k[i]++;
        if (m_k[i] == NBITS * cpb[i]) begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b1;
        end
      end else if (v) begin
        m_act[i] = 1'b1;
        m_k[i]   = 0;
      end
    end
  end

  int busy_cnt [2];
  int done_cnt [2];
  int txlow_cnt [2];
  logic bits0 [19];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [15:0] w;
      logic        t, b, d, rd;
      logic [3:0]  s;
      int          p;
      w  = (i == 0) ? word0 : word1;
      t  = (i == 0) ? tx0 : tx1;
      b  = (i == 0) ? busy0 : busy1;
      d  = (i == 0) ? done0 : done1;
      rd = (i == 0) ? rdy0 : rdy1;
      s  = (i == 0) ? sel0 : sel1;
      p  = m_k[i] / cpb[i];
      chk($sformatf("d%0d_tx", i), 32'(t), m_act[i] ? 32'(frame_bit(w, p)) : 32'd1);
      chk($sformatf("d%0d_busy", i), 32'(b), 32'(m_act[i]));
      chk($sformatf("d%0d_done", i), 32'(d), 32'(m_done[i]));
      chk($sformatf("d%0d_ready", i), 32'(rd), 32'(!m_act[i]));
      chk($sformatf("d%0d_sel", i), 32'(s), (m_act[i] && p <= 16) ? 32'(p % 16) : 32'd0);
      if (b === 1'b1) begin
        if (i == 0 && (busy_cnt[0] % C0) == 1 && (busy_cnt[0] / C0) < 19)
          bits0[busy_cnt[0] / C0] = t;
        busy_cnt[i]++;
        if (t === 1'b0) txlow_cnt[i]++;
      end
      if (d === 1'b1) done_cnt[i]++;
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; txlow_cnt[i] = 0;
    end
  endtask

  task automatic wait_done(input int i, input int target, input int maxc);
    int n = 0;
    while (done_cnt[i] < target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_done_within_bound", i), 32'(done_cnt[i] >= target), 32'd1);
  endtask

  task automatic run_frame0(input logic [15:0] w);
    @(negedge clk);
    clear_counts();
    word0 = w;
    sv0   = 1'b1;
    @(negedge clk);
    sv0   = 1'b0;
    wait_done(0, 1, 200);
    repeat (3) @(negedge clk);
  endtask

  int lit_seq [NBITS];
`ifdef TX_PARITY_EN
  int lit_init [NBITS] = '{0,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,0,1};
`else
  int lit_init [NBITS] = '{0,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,1};
`endif

  initial begin
    lit_seq = lit_init;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx0), 32'd1);
    chk("reset_ready", 32'(rdy0), 32'd1);
    chk("reset_sel", 32'(sel0), 32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Single frame of 16'hA5C3
    run_frame0(16'hA5C3);
    for (int p = 0; p < NBITS; p++)
      chk($sformatf("a5c3_bit%0d", p), 32'(bits0[p]), 32'(lit_seq[p]));
    chk("a5c3_busy_len", 32'(busy_cnt[0]), 32'(NBITS * C0));
    chk("a5c3_done_count", 32'(done_cnt[0]), 32'd1);

    // Back-to-back with start_valid held high through two frames
    @(negedge clk);
    clear_counts();
    word0 = 16'h1234;
    sv0   = 1'b1;
    wait_done(0, 1, 200);
    @(negedge clk);
    chk("b2b_busy_after_done", 32'(busy0), 32'd1);
    chk("b2b_tx_start", 32'(tx0), 32'd0);
    wait_done(0, 2, 200);
    sv0 = 1'b0;
    @(negedge clk);
    chk("b2b_no_third", 32'(busy0), 32'd0);
    chk("b2b_busy_len", 32'(busy_cnt[0]), 32'(2 * NBITS * C0));
    chk("b2b_done_count", 32'(done_cnt[0]), 32'd2);

    // Reset mid-frame, with a request presented in the reset cycle
    @(negedge clk);
    clear_counts();
    word0 = 16'hFFFF;
    sv0   = 1'b1;
    @(negedge clk);
    sv0   = 1'b0;
    for (int n = 0; n < 100 && busy_cnt[0] < 30; n++) @(negedge clk);
    chk("rst_reached_clk30", 32'(busy_cnt[0]), 32'd30);
    rst0 = 1'b1;
    sv0  = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    sv0  = 1'b0;
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_sel", 32'(sel0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    repeat (10) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt[0]), 32'd0);
    chk("rst_no_restart", 32'(busy0), 32'd0);

    // Parity patterns (odd and even population)
    run_frame0(16'h0001);
`ifdef TX_PARITY_EN
    chk("par_0001", 32'(bits0[17]), 32'd1);
    chk("par_0001_len", 32'(busy_cnt[0]), 32'd76);
`else
    chk("w0001_bit15", 32'(bits0[16]), 32'd0);
    chk("w0001_stop", 32'(bits0[17]), 32'd1);
    chk("w0001_len", 32'(busy_cnt[0]), 32'd72);
`endif
    run_frame0(16'h0003);
`ifdef TX_PARITY_EN
    chk("par_0003", 32'(bits0[17]), 32'd0);
`else
    chk("w0003_bit1", 32'(bits0[2]), 32'd1);
`endif

    // Minimum bit period on the second instance
    @(negedge clk);
    clear_counts();
    word1 = 16'hFFFF;
    sv1   = 1'b1;
    @(negedge clk);
    sv1   = 1'b0;
    wait_done(1, 1, 200);
`ifdef TX_PARITY_EN
    chk("c2_txlow", 32'(txlow_cnt[1]), 32'd4);
    chk("c2_busy_len", 32'(busy_cnt[1]), 32'd38);
`else
    chk("c2_txlow", 32'(txlow_cnt[1]), 32'd2);
    chk("c2_busy_len", 32'(busy_cnt[1]), 32'd36);
`endif
    chk("c2_done_count", 32'(done_cnt[1]), 32'd1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
